// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared types, sizes and address mapping for the cache controller
package cache_ctrl_pkg;

    localparam int MEM_BASE = 1024;
    localparam int ADDR_W   = 17;
    localparam int WORD_W   = 32;
    localparam int LINE_W   = 64;
    localparam int CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MISS = 2'd1,
        WRITE     = 2'd2
    } state_t;

    // Byte address to cache/SRAM word address, wrapping to ADDR_W bits.
    function automatic logic [ADDR_W-1:0] byte_to_word(input logic [31:0] byte_addr);
        return ADDR_W'((byte_addr - 32'(MEM_BASE)) >> 2);
    endfunction

endpackage

// File: rtl/cache_controller_if.sv
// rtl/cache_controller_if.sv - MEM-stage, cache and SRAM signals seen by the cache controller
interface cache_controller_if;

    logic                                mem_r_en;
    logic                                mem_w_en;
    logic [31:0]                         mem_addr;
    logic [31:0]                         mem_wdata;
    logic [31:0]                         mem_rdata;
    logic                                mem_ready;

    logic [cache_ctrl_pkg::ADDR_W-1:0]   cache_addr;
    logic                                cache_read_en;
    logic                                cache_write_en;
    logic                                cache_invalidate_en;
    logic [cache_ctrl_pkg::LINE_W-1:0]   cache_wdata;
    logic [31:0]                         cache_rdata;
    logic                                cache_hit;

    logic [cache_ctrl_pkg::ADDR_W-1:0]   sram_addr;
    logic [31:0]                         sram_wdata;
    logic                                sram_read_en;
    logic                                sram_write_en;
    logic [cache_ctrl_pkg::LINE_W-1:0]   sram_rdata;
    logic                                sram_ready;

    // master: the controller; slave: pipeline, cache and SRAM around it
    modport master (
        input  mem_r_en, mem_w_en, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        output cache_addr, cache_read_en, cache_write_en, cache_invalidate_en, cache_wdata,
        input  cache_rdata, cache_hit,
        output sram_addr, sram_wdata, sram_read_en, sram_write_en,
        input  sram_rdata, sram_ready
    );

    modport slave (
        output mem_r_en, mem_w_en, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        input  cache_addr, cache_read_en, cache_write_en, cache_invalidate_en, cache_wdata,
        output cache_rdata, cache_hit,
        input  sram_addr, sram_wdata, sram_read_en, sram_write_en,
        output sram_rdata, sram_ready
    );

endinterface

// File: rtl/cache_perf_counter.sv
// rtl/cache_perf_counter.sv - 16-bit event counter that sticks at all-ones
module cache_perf_counter
    import cache_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - write-through, no-write-allocate sequencer between MEM stage, cache and SRAM
// Optional hit/miss statistics ports: CACHE_CTRL_STATS_EN
module cache_controller
    import cache_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    cache_controller_if.master  bus
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
`endif
);

    state_t             state_q;
    state_t             state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [WORD_W-1:0]  wdata_q;
    logic [ADDR_W-1:0]  req_word;
    logic               load_req;
    logic               load_hit;
    logic               load_miss;

    assign req_word  = byte_to_word(bus.mem_addr);
    // A simultaneous store wins, so a load only counts when no store is present.
    assign load_req  = bus.mem_r_en && !bus.mem_w_en;
    assign load_hit  = (state_q == IDLE) && load_req && bus.cache_hit;
    assign load_miss = (state_q == IDLE) && load_req && !bus.cache_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.mem_w_en) begin
                addr_q  <= req_word;
                wdata_q <= bus.mem_wdata;
            end else if (load_miss) begin
                addr_q  <= req_word;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_w_en) begin
                    state_d = WRITE;
                end else if (load_miss) begin
                    state_d = READ_MISS;
                end
            end
            READ_MISS, WRITE: begin
                if (bus.sram_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_rdata           = '0;
        bus.mem_ready           = 1'b1;
        bus.cache_addr          = addr_q;
        bus.cache_read_en       = 1'b0;
        bus.cache_write_en      = 1'b0;
        bus.cache_invalidate_en = 1'b0;
        bus.cache_wdata         = bus.sram_rdata;
        bus.sram_addr           = {addr_q[ADDR_W-1:1], 1'b0};
        bus.sram_wdata          = wdata_q;
        bus.sram_read_en        = 1'b0;
        bus.sram_write_en       = 1'b0;
        case (state_q)
            IDLE: begin
                bus.cache_addr = req_word;
                bus.sram_addr  = {req_word[ADDR_W-1:1], 1'b0};
                if (bus.mem_w_en) begin
                    bus.cache_invalidate_en = 1'b1;
                    bus.mem_ready           = 1'b0;
                end else if (bus.mem_r_en) begin
                    bus.cache_read_en = 1'b1;
                    bus.mem_ready     = bus.cache_hit;
                    bus.mem_rdata     = bus.cache_rdata;
                end
            end
            READ_MISS: begin
                bus.sram_read_en   = 1'b1;
                bus.cache_write_en = bus.sram_ready;
                bus.mem_ready      = bus.sram_ready;
                bus.mem_rdata      = addr_q[0] ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];
            end
            WRITE: begin
                bus.sram_addr     = addr_q;
                bus.sram_write_en = 1'b1;
                bus.mem_ready     = bus.sram_ready;
            end
            default: begin
                bus.mem_ready = 1'b1;
            end
        endcase
    end

`ifdef CACHE_CTRL_STATS_EN
    cache_perf_counter u_hit_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (load_hit),
        .count (hit_count)
    );

    cache_perf_counter u_miss_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (load_miss),
        .count (miss_count)
    );
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed bench with a transaction-level model of the cache controller
module tb_cache_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_controller_if bus();

`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    cache_controller dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Outstanding transaction: 0 none, 1 load miss, 2 store.
    int          pend_kind = 0;
    logic [16:0] pend_word = '0;
    logic [31:0] pend_data = '0;
    int          m_hits    = 0;
    int          m_misses  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [16:0] w;
        logic        is_rd;
        w     = 17'((bus.mem_addr - 32'd1024) / 4);
        is_rd = bus.mem_r_en && !bus.mem_w_en;
        if (pend_kind == 0) begin
            chk("idle_strobes",
                {bus.cache_read_en, bus.cache_invalidate_en, bus.cache_write_en, bus.sram_read_en, bus.sram_write_en},
                {is_rd, bus.mem_w_en, 3'b000});
            chk("idle_ready", bus.mem_ready, bus.mem_w_en ? 1'b0 : (bus.mem_r_en ? bus.cache_hit : 1'b1));
            chk("idle_cache_addr", bus.cache_addr, w);
            if (is_rd && bus.cache_hit) chk("hit_rdata", bus.mem_rdata, bus.cache_rdata);
        end else if (pend_kind == 1) begin
            chk("miss_strobes",
                {bus.cache_read_en, bus.cache_invalidate_en, bus.cache_write_en, bus.sram_read_en, bus.sram_write_en},
                {2'b00, bus.sram_ready, 2'b10});
            chk("miss_ready", bus.mem_ready, bus.sram_ready);
            chk("miss_sram_addr", bus.sram_addr, pend_word - (pend_word % 2));
            chk("miss_cache_addr", bus.cache_addr, pend_word);
            if (bus.sram_ready) begin
                chk("miss_rdata", bus.mem_rdata, (pend_word % 2) ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0]);
                chk("fill_data", bus.cache_wdata, bus.sram_rdata);
            end
        end else begin
            chk("write_strobes",
                {bus.cache_read_en, bus.cache_invalidate_en, bus.cache_write_en, bus.sram_read_en, bus.sram_write_en},
                5'b00001);
            chk("write_ready", bus.mem_ready, bus.sram_ready);
            chk("write_sram_addr", bus.sram_addr, pend_word);
            chk("write_sram_wdata", bus.sram_wdata, pend_data);
            chk("write_cache_addr", bus.cache_addr, pend_word);
        end
`ifdef CACHE_CTRL_STATS_EN
        chk("hit_count", hit_count, 64'(m_hits));
        chk("miss_count", miss_count, 64'(m_misses));
`endif
    end

    task automatic set_idle();
        bus.mem_r_en    = 1'b0;
        bus.mem_w_en    = 1'b0;
        bus.mem_addr    = 32'd1024;
        bus.mem_wdata   = '0;
        bus.cache_rdata = '0;
        bus.cache_hit   = 1'b0;
        bus.sram_rdata  = '0;
        bus.sram_ready  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load; for a miss, SRAM answers after lat waiting cycles.
    task automatic do_load(input logic [31:0] addr, input logic hit, input logic [31:0] crd,
                           input int lat, input logic [63:0] srd,
                           output logic [31:0] rdata, output logic ready, output int busy,
                           output int fills, output logic [16:0] saddr);
        busy  = 0;
        fills = 0;
        saddr = '0;
        bus.mem_r_en    = 1'b1;
        bus.mem_addr    = addr;
        bus.cache_hit   = hit;
        bus.cache_rdata = crd;
        @(negedge clk);
        rdata = bus.mem_rdata;
        ready = bus.mem_ready;
        tick();
        if (hit) begin
            m_hits++;
        end else begin
            m_misses++;
            pend_kind = 1;
            pend_word = 17'((addr - 32'd1024) / 4);
            bus.mem_addr  = 32'hDEAD_BEE0;
            bus.cache_hit = 1'b1;
            for (int i = 0; i <= lat; i++) begin
                bus.sram_ready = (i == lat);
                bus.sram_rdata = (i == lat) ? srd : 64'hFFFF_FFFF_FFFF_FFFF;
                @(negedge clk);
                if (bus.sram_read_en && !bus.mem_ready) busy++;
                if (bus.cache_write_en) fills++;
                saddr = bus.sram_addr;
                rdata = bus.mem_rdata;
                ready = bus.mem_ready;
                tick();
            end
            pend_kind = 0;
        end
        set_idle();
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic also_read,
                            input int lat, output int invs, output int wr_cycles, output int rd_cycles,
                            output logic [16:0] saddr, output logic [31:0] swdata, output logic ready);
        invs      = 0;
        wr_cycles = 0;
        rd_cycles = 0;
        bus.mem_w_en  = 1'b1;
        bus.mem_r_en  = also_read;
        bus.mem_addr  = addr;
        bus.mem_wdata = data;
        @(negedge clk);
        if (bus.cache_invalidate_en) invs++;
        if (bus.sram_read_en) rd_cycles++;
        tick();
        pend_kind = 2;
        pend_word = 17'((addr - 32'd1024) / 4);
        pend_data = data;
        bus.mem_addr  = 32'h0000_5000;
        bus.mem_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i <= lat; i++) begin
            bus.sram_ready = (i == lat);
            @(negedge clk);
            if (bus.cache_invalidate_en) invs++;
            if (bus.sram_write_en) wr_cycles++;
            if (bus.sram_read_en) rd_cycles++;
            saddr  = bus.sram_addr;
            swdata = bus.sram_wdata;
            ready  = bus.mem_ready;
            tick();
        end
        pend_kind = 0;
        set_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdata;
        logic        ready;
        int          busy, fills, invs, wrc, rdc;
        logic [16:0] saddr;
        logic [31:0] swdata;

        rst = 1'b1;
        set_idle();
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", bus.mem_ready, 1'b1);
        chk("reset_strobes", {bus.cache_read_en, bus.cache_write_en, bus.cache_invalidate_en,
                              bus.sram_read_en, bus.sram_write_en}, 5'b00000);
        tick();

        // sram_ready while idle must be ignored
        bus.sram_ready = 1'b1;
        bus.sram_rdata = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        chk("idle_sram_ready_ignored", {bus.mem_ready, bus.cache_write_en}, 2'b10);
        tick();
        set_idle();

        do_load(32'd1024, 1'b0, 32'h0, 3, 64'h00000022_00000011, rdata, ready, busy, fills, saddr);
        chk("miss1_rdata", rdata, 32'h11);
        chk("miss1_ready", ready, 1'b1);
        chk("miss1_wait_cycles", busy, 3);
        chk("miss1_fills", fills, 1);
        chk("miss1_sram_addr", saddr, 17'd0);

        do_load(32'd1028, 1'b1, 32'h22, 0, 64'h0, rdata, ready, busy, fills, saddr);
        chk("hit_rdata_lit", rdata, 32'h22);
        chk("hit_ready_lit", ready, 1'b1);
`ifdef CACHE_CTRL_STATS_EN
        @(negedge clk);
        chk("hit_count_lit", hit_count, 16'd1);
        chk("miss_count_lit", miss_count, 16'd1);
`endif

        do_store(32'd1036, 32'hABCD, 1'b0, 2, invs, wrc, rdc, saddr, swdata, ready);
        chk("store_invalidates", invs, 1);
        chk("store_write_cycles", wrc, 3);
        chk("store_sram_addr", saddr, 17'd3);
        chk("store_sram_wdata", swdata, 32'hABCD);
        chk("store_ready", ready, 1'b1);

        // back-to-back: load presented in the cycle right after the store completes
        do_load(32'd1028, 1'b0, 32'h0, 1, 64'h00000055_00000044, rdata, ready, busy, fills, saddr);
        chk("miss_odd_rdata", rdata, 32'h55);
        chk("miss_odd_sram_addr", saddr, 17'd0);
        chk("miss_odd_fills", fills, 1);

        // address wraps to 17 bits: word (2^17 + 7) maps to 7, pair base 6
        do_load(32'd1024 + 32'd4 * (32'd131072 + 32'd7), 1'b0, 32'h0, 0, 64'h00000099_00000088,
                rdata, ready, busy, fills, saddr);
        chk("wrap_rdata", rdata, 32'h99);
        chk("wrap_sram_addr", saddr, 17'd6);

        // reset during a miss aborts it with no fill
        bus.mem_r_en  = 1'b1;
        bus.mem_addr  = 32'd1040;
        bus.cache_hit = 1'b0;
        tick();
        m_misses++;
        pend_kind = 1;
        pend_word = 17'd4;
        tick();
        bus.mem_r_en   = 1'b0;
        bus.sram_ready = 1'b1;
        bus.sram_rdata = 64'h00000077_00000066;
        rst       = 1'b1;
        pend_kind = 0;
        m_hits    = 0;
        m_misses  = 0;
        #1;
        chk("rst_sram_read_en", bus.sram_read_en, 1'b0);
        chk("rst_cache_write_en", bus.cache_write_en, 1'b0);
        chk("rst_ready", bus.mem_ready, 1'b1);
        tick();
        rst = 1'b0;
        set_idle();
        @(negedge clk);
        chk("post_rst_idle", {bus.sram_read_en, bus.cache_write_en, bus.mem_ready}, 3'b001);
        tick();

        do_store(32'd1044, 32'h1234, 1'b1, 1, invs, wrc, rdc, saddr, swdata, ready);
        chk("both_sram_reads", rdc, 0);
        chk("both_write_cycles", wrc, 2);
        chk("both_sram_addr", saddr, 17'd5);
        chk("both_sram_wdata", swdata, 32'h1234);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
